// File: rtl/systolic_array_scheduler_pkg.sv
// Shared definitions for the systolic array scheduler: opcodes, FSM states,
// instruction field layout and the flush-length helper.
package systolic_pkg;

    localparam int unsigned ARR_SIZE_DEF = 4;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LDW   = 4'd1;
    localparam logic [3:0] OP_ACT   = 4'd2;
    localparam logic [3:0] OP_FLUSH = 4'd3;
    localparam logic [3:0] OP_DRAIN = 4'd4;

    localparam int unsigned OPC_LSB = 60;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned IDX_LSB = 32;
    localparam int unsigned IDX_W   = 16;
    localparam int unsigned PL_LSB  = 0;
    localparam int unsigned PL_W    = 32;

    // A wavefront needs 2N-1 advances to leave an N x N array completely
    function automatic int unsigned flush_cycles(input int unsigned n);
        return 2 * n - 1;
    endfunction

    localparam int unsigned FLUSH_CYCLES = flush_cycles(ARR_SIZE_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDW,
        S_ACT,
        S_FLUSH,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/systolic_array_scheduler_down_counter.sv
// Loadable down-counter with zero flag; times the flush phase of the scheduler.
module sched_down_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/systolic_array_scheduler.sv
// Instruction-driven sequencer for a weight-stationary systolic array.
// Optional macro SCHED_PERF_CNT_EN adds perf_cycles (saturating arr_en cycle count).
module systolic_array_scheduler
    import systolic_pkg::*;
#(
    parameter int unsigned ARR_SIZE = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 32,
    localparam int unsigned SEL_W   = $clog2(ARR_SIZE),
    localparam int unsigned VEC_W   = ARR_SIZE * DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [63:0]      instr,
    output logic             instr_ready,
    output logic             arr_en,
    output logic             w_load,
    output logic [SEL_W-1:0] w_row,
    output logic [VEC_W-1:0] w_data,
    output logic             act_valid,
    output logic [VEC_W-1:0] act_data,
    output logic [SEL_W-1:0] res_sel,
    input  logic [ACC_W-1:0] res_data,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
`ifdef SCHED_PERF_CNT_EN
    ,output logic [31:0]     perf_cycles
`endif
);

    localparam int unsigned FLUSH_N = flush_cycles(ARR_SIZE);
    localparam int unsigned CNT_W   = $clog2(FLUSH_N + 1);

    state_e               state_q, state_d;
    logic                 arr_en_q, arr_en_d;
    logic                 w_load_q, w_load_d;
    logic [SEL_W-1:0]     w_row_q, w_row_d;
    logic [VEC_W-1:0]     w_data_q, w_data_d;
    logic                 act_valid_q, act_valid_d;
    logic [VEC_W-1:0]     act_data_q, act_data_d;
    logic [SEL_W-1:0]     res_sel_q, res_sel_d;
    logic                 out_valid_q, out_valid_d;
    logic [ARR_SIZE-1:0]  w_loaded_q, w_loaded_d;
    logic                 err_q, err_d;

    logic                 cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]     cnt_value;

    logic [OPC_W-1:0]     opc;
    logic [IDX_W-1:0]     idx;
    logic [PL_W-1:0]      payload;
    logic                 idx_ok;
    logic                 accept;
    logic                 unused_bits;

    assign opc     = instr[OPC_LSB +: OPC_W];
    assign idx     = instr[IDX_LSB +: IDX_W];
    assign payload = instr[PL_LSB +: PL_W];
    assign idx_ok  = (idx < IDX_W'(ARR_SIZE));
    assign unused_bits = ^{instr[59:48], cnt_value};

    assign instr_ready = (state_q == S_IDLE) & rst;
    assign accept      = instr_valid & instr_ready;

    sched_down_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(FLUSH_N - 1)),
        .dec_i      (cnt_dec),
        .count_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        arr_en_d    = 1'b0;
        w_load_d    = 1'b0;
        w_row_d     = '0;
        w_data_d    = '0;
        act_valid_d = 1'b0;
        act_data_d  = '0;
        out_valid_d = 1'b0;
        res_sel_d   = res_sel_q;
        w_loaded_d  = w_loaded_q;
        err_d       = err_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opc)
                        OP_NOP: ;
                        OP_LDW: begin
                            state_d = S_LDW;
                            if (idx_ok) begin
                                w_load_d = 1'b1;
                                w_row_d  = idx[SEL_W-1:0];
                                w_data_d = payload[VEC_W-1:0];
                                w_loaded_d[idx[SEL_W-1:0]] = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_ACT: begin
                            state_d = S_ACT;
                            if (&w_loaded_q) begin
                                act_valid_d = 1'b1;
                                arr_en_d    = 1'b1;
                                act_data_d  = payload[VEC_W-1:0];
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_FLUSH: begin
                            state_d  = S_FLUSH;
                            arr_en_d = 1'b1;
                            cnt_load = 1'b1;
                        end
                        OP_DRAIN: begin
                            state_d     = S_DRAIN;
                            out_valid_d = 1'b1;
                            res_sel_d   = '0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LDW, S_ACT: state_d = S_IDLE;
            S_FLUSH: begin
                // Counter was loaded with N-1, so counts N-1..0 give N enabled cycles
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    arr_en_d = 1'b1;
                    cnt_dec  = 1'b1;
                end
            end
            S_DRAIN: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    if (res_sel_q == SEL_W'(ARR_SIZE - 1)) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        res_sel_d   = '0;
                    end else begin
                        res_sel_d = res_sel_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            arr_en_q    <= 1'b0;
            w_load_q    <= 1'b0;
            w_row_q     <= '0;
            w_data_q    <= '0;
            act_valid_q <= 1'b0;
            act_data_q  <= '0;
            res_sel_q   <= '0;
            out_valid_q <= 1'b0;
            w_loaded_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            arr_en_q    <= arr_en_d;
            w_load_q    <= w_load_d;
            w_row_q     <= w_row_d;
            w_data_q    <= w_data_d;
            act_valid_q <= act_valid_d;
            act_data_q  <= act_data_d;
            res_sel_q   <= res_sel_d;
            out_valid_q <= out_valid_d;
            w_loaded_q  <= w_loaded_d;
            err_q       <= err_d;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (arr_en_q && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign arr_en    = arr_en_q;
    assign w_load    = w_load_q;
    assign w_row     = w_row_q;
    assign w_data    = w_data_q;
    assign act_valid = act_valid_q;
    assign act_data  = act_data_q;
    assign res_sel   = res_sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_data;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

endmodule
